// File: rtl/fft_pkg.sv
// Shared constants, FSM state encoding and the saturation helper for the
// FFT stage-7 butterfly.
package fft_pkg;

    localparam int DW        = 12;
    localparam int PW        = 24;
    localparam int Q7_SHIFT  = 7;
    localparam int Q7_ONE    = 1 << Q7_SHIFT;
    // The multiplier shifts its product right logically, so only the low
    // 17 bits carry a meaningful two's-complement W*Y value.
    localparam int WY_RAW_W  = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    function automatic logic signed [31:0] sat(input logic signed [31:0] value,
                                               input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/bf_addsub_sat.sv
// One real or imaginary lane of the butterfly combine step.
// The combine adds and subtracts W*Y, halves the result and saturates it.
module bf_addsub_sat #(
    parameter int DW = fft_pkg::DW
) (
    input  logic [DW-1:0]                x_i,
    input  logic [fft_pkg::WY_RAW_W-1:0] p_i,
    output logic [DW-1:0]                top_o,
    output logic [DW-1:0]                bot_o
);
    import fft_pkg::*;

    localparam int WY_W  = DW + 1;
    localparam int SUM_W = DW + 2;

    logic signed [WY_RAW_W-1:0] wy_raw;
    logic signed [WY_W-1:0]     wy;
    logic signed [SUM_W-1:0]    x_ext;
    logic signed [SUM_W-1:0]    wy_ext;
    logic signed [SUM_W-1:0]    sum;
    logic signed [SUM_W-1:0]    dif;
    logic signed [SUM_W-1:0]    sum_sh;
    logic signed [SUM_W-1:0]    dif_sh;

    assign wy_raw = signed'(p_i);
    assign wy     = WY_W'(sat(32'(wy_raw), WY_W));

    // SUM_W leaves one guard bit, so neither X+wy nor X-wy can wrap.
    assign x_ext  = SUM_W'(signed'(x_i));
    assign wy_ext = SUM_W'(wy);
    assign sum    = x_ext + wy_ext;
    assign dif    = x_ext - wy_ext;
    assign sum_sh = sum >>> 1;
    assign dif_sh = dif >>> 1;

    assign top_o  = DW'(sat(32'(sum_sh), DW));
    assign bot_o  = DW'(sat(32'(dif_sh), DW));

endmodule

// File: rtl/fft_butterfly_7.sv
// Stage-7 radix-2 DIT butterfly. It sequences the external complex multiplier,
// combines X with W*Y, and counts the butterflies in each frame.
module fft_butterfly_7 #(
    parameter int DW      = fft_pkg::DW,
    parameter int PW      = fft_pkg::PW,
    parameter int N_PAIRS = 256,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x_re,
    input  logic [DW-1:0] x_im,
    input  logic [DW-1:0] y_re,
    input  logic [DW-1:0] y_im,
    input  logic [DW-1:0] w_re,
    input  logic [DW-1:0] w_im,
    output logic [DW-1:0] mult_a,
    output logic [DW-1:0] mult_b,
    output logic [DW-1:0] mult_c,
    output logic [DW-1:0] mult_d,
    output logic          mult_en,
    input  logic          mult_done,
    input  logic [PW-1:0] mult_real,
    input  logic [PW-1:0] mult_img,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] top_re,
    output logic [DW-1:0] top_im,
    output logic [DW-1:0] bot_re,
    output logic [DW-1:0] bot_im,
    output logic          frame_done,
    output logic [CW-1:0] bf_idx
);
    import fft_pkg::*;

    state_e                    state_q, state_d;
    logic                      in_ready_q;
    logic [DW-1:0]             x_re_q, x_im_q, y_re_q, y_im_q, w_re_q, w_im_q;
    logic [1:0][WY_RAW_W-1:0]  prod_q;
    logic [1:0][DW-1:0]        top_q, bot_q;
    logic [CW-1:0]             bf_idx_q;

    logic                      accept, mult_cap, handshake, last_pair;
    logic [1:0][DW-1:0]        lane_x, lane_top, lane_bot;
    logic                      unused_prod_hi;

    assign accept    = in_valid & in_ready_q;
    assign mult_cap  = (state_q == ST_MUL) & mult_done;
    assign handshake = (state_q == ST_OUT) & out_ready;
    assign last_pair = (bf_idx_q == CW'(N_PAIRS - 1));

    assign unused_prod_hi = ^{mult_real[PW-1:WY_RAW_W], mult_img[PW-1:WY_RAW_W]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)    state_d = ST_MUL;
            ST_MUL:  if (mult_done) state_d = ST_ADD;
            ST_ADD:                 state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // in_ready is registered so it stays low throughout reset and rises on the
    // first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            bf_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == ST_IDLE);
            if (handshake) begin
                bf_idx_q <= last_pair ? '0 : bf_idx_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_re_q <= '0;
            x_im_q <= '0;
            y_re_q <= '0;
            y_im_q <= '0;
            w_re_q <= '0;
            w_im_q <= '0;
            prod_q <= '0;
            top_q  <= '0;
            bot_q  <= '0;
        end else begin
            if (accept) begin
                x_re_q <= x_re;
                x_im_q <= x_im;
                y_re_q <= y_re;
                y_im_q <= y_im;
                w_re_q <= w_re;
                w_im_q <= w_im;
            end
            if (mult_cap) begin
                prod_q[0] <= mult_real[WY_RAW_W-1:0];
                prod_q[1] <= mult_img[WY_RAW_W-1:0];
            end
            if (state_q == ST_ADD) begin
                top_q <= lane_top;
                bot_q <= lane_bot;
            end
        end
    end

    assign lane_x[0] = x_re_q;
    assign lane_x[1] = x_im_q;

    // Lane 0 is the real lane and lane 1 is the imaginary lane.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        bf_addsub_sat #(
            .DW(DW)
        ) u_lane (
            .x_i   (lane_x[gi]),
            .p_i   (prod_q[gi]),
            .top_o (lane_top[gi]),
            .bot_o (lane_bot[gi])
        );
    end

    assign in_ready   = in_ready_q;
    assign mult_en    = (state_q == ST_MUL);
    assign mult_a     = y_re_q;
    assign mult_b     = y_im_q;
    assign mult_c     = w_re_q;
    assign mult_d     = w_im_q;
    assign out_valid  = (state_q == ST_OUT);
    assign top_re     = top_q[0];
    assign top_im     = top_q[1];
    assign bot_re     = bot_q[0];
    assign bot_im     = bot_q[1];
    assign frame_done = handshake & last_pair;
    assign bf_idx     = bf_idx_q;

endmodule

// File: tb/tb_fft_butterfly_7.sv
// Directed bench for fft_butterfly_7. A four-pair frame keeps the wrap short,
// and the multiplier responses come from hand-computed products.
module tb_fft_butterfly_7;
    localparam int DW = 12;
    localparam int PW = 24;
    localparam int NP = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] x_re = '0, x_im = '0, y_re = '0, y_im = '0, w_re = '0, w_im = '0;
    logic [DW-1:0] mult_a, mult_b, mult_c, mult_d;
    logic          mult_en;
    logic          mult_done = 1'b0;
    logic [PW-1:0] mult_real = '0, mult_img = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] top_re, top_im, bot_re, bot_im;
    logic          frame_done;
    logic [CW-1:0] bf_idx;

    int checks = 0;
    int failures = 0;
    int exp_idx = 0;

    always #5 clk = ~clk;

    fft_butterfly_7 #(.DW(DW), .PW(PW), .N_PAIRS(NP), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im), .w_re(w_re), .w_im(w_im),
        .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c), .mult_d(mult_d),
        .mult_en(mult_en), .mult_done(mult_done), .mult_real(mult_real), .mult_img(mult_img),
        .out_valid(out_valid), .out_ready(out_ready),
        .top_re(top_re), .top_im(top_im), .bot_re(bot_re), .bot_im(bot_im),
        .frame_done(frame_done), .bf_idx(bf_idx)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", int'(in_ready), 1);
    endtask

    task automatic check_outputs(input string tag, input int etr, input int eti,
                                 input int ebr, input int ebi);
        check({tag, "_top_re"}, int'($signed(top_re)), etr);
        check({tag, "_top_im"}, int'($signed(top_im)), eti);
        check({tag, "_bot_re"}, int'($signed(bot_re)), ebr);
        check({tag, "_bot_im"}, int'($signed(bot_im)), ebi);
    endtask

    task automatic run_bf(input int xr, input int xi, input int yr, input int yi,
                          input int wr, input int wi,
                          input logic [PW-1:0] mr, input logic [PW-1:0] mi,
                          input int lat, input int hold,
                          input int etr, input int eti, input int ebr, input int ebi);
        @(negedge clk);
        wait_ready();
        x_re = DW'(xr); x_im = DW'(xi);
        y_re = DW'(yr); y_im = DW'(yi);
        w_re = DW'(wr); w_im = DW'(wi);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mul_en", int'(mult_en), 1);
        check("mul_in_ready", int'(in_ready), 0);
        check("mul_a", int'($signed(mult_a)), yr);
        check("mul_b", int'($signed(mult_b)), yi);
        check("mul_c", int'($signed(mult_c)), wr);
        check("mul_d", int'($signed(mult_d)), wi);
        check("mul_frame_done", int'(frame_done), 0);
        repeat (lat) begin
            @(negedge clk);
            check("mul_wait_en", int'(mult_en), 1);
            check("mul_wait_a", int'($signed(mult_a)), yr);
        end
        mult_real = mr;
        mult_img  = mi;
        mult_done = 1'b1;
        @(negedge clk);
        mult_done = 1'b0;
        mult_real = '0;
        mult_img  = '0;
        check("add_out_valid", int'(out_valid), 0);
        check("add_mult_en", int'(mult_en), 0);
        @(negedge clk);
        check("out_valid", int'(out_valid), 1);
        check("out_in_ready", int'(in_ready), 0);
        check_outputs("out", etr, eti, ebr, ebi);
        repeat (hold) begin
            mult_done = 1'b1;
            mult_real = 24'h000777;
            mult_img  = 24'h000333;
            @(negedge clk);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_frame_done", int'(frame_done), 0);
            check_outputs("hold", etr, eti, ebr, ebi);
        end
        mult_done = 1'b0;
        mult_real = '0;
        mult_img  = '0;
        check("pre_hs_idx", int'(bf_idx), exp_idx);
        out_ready = 1'b1;
        #1;
        check("hs_frame_done", int'(frame_done), (exp_idx == NP - 1) ? 1 : 0);
        @(negedge clk);
        out_ready = 1'b0;
        exp_idx = (exp_idx + 1) % NP;
        check("post_hs_out_valid", int'(out_valid), 0);
        check("post_hs_frame_done", int'(frame_done), 0);
        check("post_hs_idx", int'(bf_idx), exp_idx);
        $display("bf x=(%0d,%0d) y=(%0d,%0d) w=(%0d,%0d) -> top=(%0d,%0d) bot=(%0d,%0d) next_idx=%0d",
                 xr, xi, yr, yi, wr, wi, $signed(top_re), $signed(top_im),
                 $signed(bot_re), $signed(bot_im), bf_idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 rst_n = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_mult_en", int'(mult_en), 0);
        check("rst_bf_idx", int'(bf_idx), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check_outputs("rst", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", int'(in_ready), 1);

        // Identity twiddle; mult_done comes in the third cycle of mult_en.
        run_bf(100, 50, 20, -10, 128, 0, 24'h000014, 24'h01FFF6, 2, 0, 60, 20, 40, 30);
        // Negative product that arrives only as a 17-bit pattern after the logical shift.
        run_bf(0, 0, -20, 10, 128, 0, 24'h01FFEC, 24'h00000A, 1, 0, -10, 5, 10, -5);
        // wy saturates to 4095, and the top output saturates as well.
        run_bf(2047, 0, 2047, 0, 2047, 0, 24'd32736, 24'd0, 0, 0, 2047, 0, -1024, 0);
        // W = j, with backpressure and stray mult_done pulses; this is the frame's last pair.
        run_bf(-100, 7, 30, 40, 0, 128, 24'h01FFD8, 24'h00001E, 1, 10, -70, 18, -30, -12);
        // Junk upper product bits, negative wy saturation, and floor on the shift.
        run_bf(-2048, -3, 0, 0, 128, 0, 24'hFF0000, 24'h000000, 0, 0, -2048, -2, 1024, -2);

        // Assert reset while the multiplier is busy.
        @(negedge clk);
        wait_ready();
        x_re = DW'(5); x_im = DW'(6); y_re = DW'(7); y_im = DW'(8);
        w_re = DW'(128); w_im = DW'(0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstmul_en_before", int'(mult_en), 1);
        rst_n = 1'b0;
        #1;
        check("rstmul_mult_en", int'(mult_en), 0);
        check("rstmul_in_ready", int'(in_ready), 0);
        check("rstmul_bf_idx", int'(bf_idx), 0);
        check("rstmul_mult_a", int'($signed(mult_a)), 0);
        check_outputs("rstmul", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_idx = 0;
        @(negedge clk);
        mult_done = 1'b1;
        mult_real = 24'h000007;
        mult_img  = 24'h000008;
        @(negedge clk);
        mult_done = 1'b0;
        mult_real = '0;
        mult_img  = '0;
        check("rstmul_post_in_ready", int'(in_ready), 1);
        check("rstmul_post_mult_en", int'(mult_en), 0);
        check("rstmul_post_bf_idx", int'(bf_idx), 0);
        repeat (3) begin
            @(negedge clk);
            check("rstmul_no_out_valid", int'(out_valid), 0);
            check_outputs("rstmul_post", 0, 0, 0, 0);
        end
        $display("reset during MUL: in_ready=%0d out_valid=%0d bf_idx=%0d", in_ready, out_valid, bf_idx);

        // The counter restarts from zero after reset.
        run_bf(100, 50, 20, -10, 128, 0, 24'h000014, 24'h01FFF6, 0, 0, 60, 20, 40, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_butterfly_7.md
Name: fft_butterfly_7

Overview:
Radix-2 DIT butterfly control and combine stage for FFT stage 7. It sits directly downstream of the stage-7 complex multiplier, which it drives with the Y operand and twiddle W. It consumes the multiplier's scaled W·Y product and produces X+W·Y and X−W·Y. A valid/ready handshake connects it to the stage-7 sample buffer upstream and the stage-8 buffer downstream. It also counts butterflies per frame and flags frame completion.

Parameters:
DW, 12, sample and twiddle width (signed two's complement; twiddle in Q7, 1.0 = 128)
PW, 24, multiplier product port width
N_PAIRS, 256, butterflies per frame
CW, 8, butterfly counter width, equal to clog2(N_PAIRS)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  upstream operands valid
in_ready  out  1  block can accept operands
x_re, x_im  in  DW each  butterfly top input X
y_re, y_im  in  DW each  butterfly bottom input Y
w_re, w_im  in  DW each  twiddle W
mult_a, mult_b, mult_c, mult_d  out  DW each  multiplier operands: a=y_re, b=y_im, c=w_re, d=w_im
mult_en  out  1  multiplier enable
mult_done  in  1  single-cycle pulse: multiplier result valid this cycle
mult_real, mult_img  in  PW each  multiplier result (Re/Im of W·Y, already >>7, logical shift)
out_valid  out  1  results valid
out_ready  in  1  downstream accepts
top_re, top_im  out  DW each  (X+W·Y)/2, saturated
bot_re, bot_im  out  DW each  (X−W·Y)/2, saturated
frame_done  out  1  one-cycle pulse when the N_PAIRS-th result handshakes
bf_idx  out  CW  index of the butterfly currently in flight

Behaviour:
- Clock and reset: single clock clk. Asynchronous active-low reset rst_n.
- Reset values:
  - all outputs 0, except in_ready = 0 during reset and 1 in the first cycle after release
  - state = IDLE, bf_idx = 0
- FSM states: IDLE, MUL, ADD, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register X, Y and W, then go to MUL.
- MUL:
  - mult_en = 1 and mult_a..d are driven from registers, stable for the whole state.
  - Stay in MUL until mult_done = 1, then capture mult_real/mult_img and go to ADD.
  - mult_done seen outside MUL is ignored.
- ADD (one cycle):
  - wy_re = signed(mult_real[16:0]), wy_im = signed(mult_img[16:0]). Bits [16:0] are used because the upstream shift is logical; sign is bit 16.
  - Saturate each wy to 13-bit signed [-4096, 4095].
  - Sign-extend X and wy to 14 bits. s = X + wy, d = X − wy.
  - Arithmetic shift right by 1 (per-stage scaling), then saturate to DW: [-2048, 2047].
  - Register into top_*/bot_* and go to OUT.
- OUT:
  - out_valid = 1. Outputs are held stable until out_ready.
  - On out_valid & out_ready:
    - if bf_idx == N_PAIRS−1: pulse frame_done and wrap bf_idx to 0
    - otherwise bf_idx increments
    - next state IDLE; out_valid drops the following cycle
- Latency:
  - operands accepted at edge 0; mult_en high from cycle 1
  - mult_done at cycle k means out_valid at cycle k+2
  - minimum issue interval is k+3 cycles when out_ready is constantly 1
- Not pipelined: in_ready = 0 in MUL, ADD and OUT. Backpressure in OUT stalls indefinitely with no data loss.
- Reset asserted mid-operation: immediate return to reset values. The in-flight butterfly is discarded and bf_idx = 0. A mult_done arriving after reset release is ignored because the state is IDLE.
- frame_done and the bf_idx wrap occur only on the handshake cycle, never on capture.

Decomposition:
- Shared package fft_pkg holds:
  - DW, PW and the Q7 scale constant
  - the FSM state enum
  - saturate function sat(value, width)
- One sub-module, bf_addsub_sat: purely combinational add/sub, shift and saturate for one real/imag lane.
  - Instantiated twice (re, im).
  - Provides both the top and bottom outputs.
- The multiplier stays external. The parent stage wires mult_* to it and generates mult_done from the AND of its ready flags.

Test Plan:
- Identity twiddle: x=(100,50), y=(20,-10), w=(128,0); model returns mult=(20,-10) 3 cycles after mult_en. Expect top=(60,20), bot=(40,30), out_valid at cycle 5.
- Negative product via logical shift: y=(-20,10), w=(128,0), mult_real = 0x01FFEC (−20 in 17 bits). Expect wy_re=−20; with x=(0,0): top=(−10,5), bot=(10,−5).
- Saturation: x=(2047,0), y=(2047,0), w=(2047,0), mult_real=32736. Expect wy saturated to 4095, top_re=2047, bot_re=−1024.
- Backpressure: hold out_ready=0 for 10 cycles in OUT. Outputs remain constant, in_ready stays 0 and extra mult_done pulses are ignored; release gives exactly one handshake.
- Frame wrap with N_PAIRS=4: run 4 butterflies. frame_done pulses once, on the 4th handshake only, and bf_idx sequence is 0,1,2,3,0.
- Reset in MUL: deassert rst_n while mult_en=1, then pulse mult_done after release. Expect all outputs 0, no out_valid, in_ready=1, bf_idx=0.
